quiz_round_ctrl: RTL and testbench
==================================

// Module: quiz_round_ctrl
// PURPOSE
//  Round sequencer for the 4-player quiz buzzer system.
//  - Host-driven flow: host opens a grab window, first eligible player key wins the answer slot,
//    then the host judges the answer.
//  - Detects false starts, runs the grab and answer countdowns, keeps per-player scores and
//    drives the buzzer.
//  - Sits between the debounced key inputs and the display/score logic.
// PARAMETERS
//  TICK_CYCLES   5_000_000  CLK cycles per 0.1 s tick (50 MHz)
//  GRAB_TICKS    90         grab window length in ticks (9.0 s)
//  ANSWER_TICKS  200        answer window length in ticks (20.0 s)
//  BEEP_TICKS    5          buzzer pulse length in ticks (0.5 s)
//  SCORE_W       4          score width per player
// PORTS
//  CLK            in   1          system clock
//  RSTn           in   1          async active-low reset
//  Host_Start     in   1          1-cycle pulse, debounced: open round / return to idle
//  Judge_Right    in   1          1-cycle pulse: answer correct
//  Judge_Wrong    in   1          1-cycle pulse: answer wrong
//  Score_Clr      in   1          1-cycle pulse: zero all scores
//  Player_Key     in   4          debounced levels, bit i = player i+1, active high
//  Player_Number  out  4          winner 1..4, 0 = none
//  Buzzer_Answer  out  1          buzzer drive, active high
//  Timer_Start    out  1          1 while a countdown runs (ARMED/ANSWER)
//  Remain_Ticks   out  8          remaining ticks of the active window
//  Foul           out  4          false-start flags per player
//  Score_Bus      out  4*SCORE_W  player i score at [i*SCORE_W +: SCORE_W]
//  State          out  2          0 IDLE, 1 ARMED, 2 ANSWER, 3 DONE
// BEHAVIOUR
//  Reset (async, RSTn low):
//   - State=IDLE; all outputs 0; key-edge history = 4'b1111, so a key held at reset makes no edge.
//  Key events and arbitration:
//   - Key event = rising edge of Player_Key[i], using the registered previous value.
//   - Simultaneous events: the lowest index wins.
//  Tick counter:
//   - Counts 0..TICK_CYCLES-1 and clears on entry to ARMED/ANSWER.
//   - First decrement happens TICK_CYCLES cycles after entry.
//  IDLE:
//   - Remain_Ticks=0, Timer_Start=0.
//   - Key event on player i sets Foul[i] and starts a beep.
//   - Host_Start -> ARMED; Remain_Ticks=GRAB_TICKS, Timer_Start=1.
//  ARMED:
//   - Remain_Ticks decrements on each tick.
//   - A key event from a player with Foul[i]=0 -> ANSWER; Player_Number=i+1,
//     Remain_Ticks=ANSWER_TICKS, beep.
//   - Keys of fouled players are ignored.
//   - Remain_Ticks reaching 0 -> DONE; Player_Number=0, Timer_Start=0, beep.
//   - Grab and expiry in the same cycle: grab wins.
//  ANSWER:
//   - Remain_Ticks decrements on each tick.
//   - Judge_Right -> winner score +1, saturating at 2^SCORE_W-1; go to DONE.
//   - Judge_Wrong or expiry -> winner score -1, floor 0; go to DONE.
//   - Right and Wrong asserted in the same cycle: both ignored.
//   - Judge pulse coinciding with expiry: the judge pulse wins.
//  DONE:
//   - Timer_Start=0, Remain_Ticks holds; Player_Number holds.
//   - Host_Start -> IDLE; clears Foul and Player_Number.
//  Ignored inputs:
//   - Host_Start in ARMED or ANSWER.
//   - Judge pulses outside ANSWER.
//  Score_Clr:
//   - Zeroes all scores in any state.
//   - Takes priority over a same-cycle score update.
//  Buzzer:
//   - Each beep trigger restarts a BEEP_TICKS-long pulse; the beep timer is independent of
//     the state timers.
//   - Buzzer_Answer goes high the cycle after the trigger.
// TESTING (TICK_CYCLES=4, GRAB_TICKS=9, ANSWER_TICKS=5, BEEP_TICKS=2)
//  1. Start, then a P3 edge at cycle 10 -> State=2, Player_Number=3, Remain_Ticks=5,
//     Buzzer high for 8 cycles.
//  2. P2 and P4 rise in the same cycle in ARMED -> Player_Number=2; later Judge_Right ->
//     score2=1, State=3.
//  3. P1 pressed in IDLE -> Foul=4'b0001; after Start, a P1 edge is ignored and a P1+P2 edge
//     -> Player_Number=2.
//  4. No key after Start -> Remain_Ticks 9..0; DONE 36 cycles after Start, Player_Number=0,
//     beep.
//  5. Score at 15, Judge_Right -> stays 15; score 0 with answer timeout -> stays 0.
//  6. RSTn low mid-ANSWER with P1 held -> all outputs 0; after release no foul and no event
//     from P1.

Source files
------------

// File: rtl/quiz_round_ctrl.sv
// Round sequencer for the 4-player quiz buzzer: grab arbitration, false-start
// detection, grab/answer countdowns, per-player scores and buzzer pulse.
module quiz_round_ctrl #(
  parameter int unsigned TICK_CYCLES  = 5_000_000,
  parameter int unsigned GRAB_TICKS   = 90,
  parameter int unsigned ANSWER_TICKS = 200,
  parameter int unsigned BEEP_TICKS   = 5,
  parameter int unsigned SCORE_W      = 4
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   Host_Start,
  input  logic                   Judge_Right,
  input  logic                   Judge_Wrong,
  input  logic                   Score_Clr,
  input  logic [3:0]             Player_Key,
  output logic [3:0]             Player_Number,
  output logic                   Buzzer_Answer,
  output logic                   Timer_Start,
  output logic [7:0]             Remain_Ticks,
  output logic [3:0]             Foul,
  output logic [4*SCORE_W-1:0]   Score_Bus,
  output logic [1:0]             State
);

  localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS + 1) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_ANSWER = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           key_prev_q;
  logic [3:0]           foul_q, foul_d;
  logic [3:0]           pn_q, pn_d;
  logic                 timer_q, timer_d;
  logic [7:0]           remain_q, remain_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [4*SCORE_W-1:0] score_q, score_d;
  logic                 buzz_q, buzz_d;
  logic [TW-1:0]        beep_cnt_q, beep_cnt_d;
  logic [BW-1:0]        beep_rem_q, beep_rem_d;

  logic [3:0]           key_evt, elig, grab_num;
  logic                 tick, expire, beep_trig, score_inc, score_dec;
  logic [SCORE_W-1:0]   cur;

  always_comb begin
    key_evt = Player_Key & ~key_prev_q;
    elig    = key_evt & ~foul_q;
    if (elig[0])      grab_num = 4'd1;
    else if (elig[1]) grab_num = 4'd2;
    else if (elig[2]) grab_num = 4'd3;
    else if (elig[3]) grab_num = 4'd4;
    else              grab_num = 4'd0;

    tick   = (tick_cnt_q == TICK_MAX);
    expire = tick && (remain_q <= 8'd1);

    state_d    = state_q;
    foul_d     = foul_q;
    pn_d       = pn_q;
    timer_d    = timer_q;
    remain_d   = remain_q;
    tick_cnt_d = '0;
    beep_trig  = 1'b0;
    score_inc  = 1'b0;
    score_dec  = 1'b0;

    if (state_q == S_ARMED || state_q == S_ANSWER)
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (|key_evt) begin
          foul_d    = foul_q | key_evt;
          beep_trig = 1'b1;
        end
        if (Host_Start) begin
          state_d    = S_ARMED;
          remain_d   = 8'(GRAB_TICKS);
          timer_d    = 1'b1;
          tick_cnt_d = '0;
        end
      end
      S_ARMED: begin
        if (tick && remain_q != '0) remain_d = remain_q - 8'd1;
        // A grab on the expiry tick still wins the round.
        if (|elig) begin
          state_d    = S_ANSWER;
          pn_d       = grab_num;
          remain_d   = 8'(ANSWER_TICKS);
          tick_cnt_d = '0;
          beep_trig  = 1'b1;
        end else if (expire) begin
          state_d   = S_DONE;
          pn_d      = 4'd0;
          timer_d   = 1'b0;
          remain_d  = '0;
          beep_trig = 1'b1;
        end
      end
      S_ANSWER: begin
        if (tick && remain_q != '0) remain_d = remain_q - 8'd1;
        if (Judge_Right ^ Judge_Wrong) begin
          state_d   = S_DONE;
          timer_d   = 1'b0;
          score_inc = Judge_Right;
          score_dec = Judge_Wrong;
        end else if (expire) begin
          state_d   = S_DONE;
          timer_d   = 1'b0;
          remain_d  = '0;
          score_dec = 1'b1;
        end
      end
      S_DONE: begin
        if (Host_Start) begin
          state_d  = S_IDLE;
          foul_d   = '0;
          pn_d     = 4'd0;
          remain_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    score_d = score_q;
    cur     = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cur = score_q[i*SCORE_W +: SCORE_W];
      if (pn_q == 4'(i + 1)) begin
        if (score_inc && cur != '1) cur = cur + 1'b1;
        if (score_dec && cur != '0) cur = cur - 1'b1;
      end
      score_d[i*SCORE_W +: SCORE_W] = cur;
    end
    if (Score_Clr) score_d = '0;

    // Beep pulse runs on its own tick prescaler so a retrigger restarts it cleanly.
    buzz_d     = buzz_q;
    beep_cnt_d = beep_cnt_q;
    beep_rem_d = beep_rem_q;
    if (beep_trig) begin
      buzz_d     = 1'b1;
      beep_cnt_d = '0;
      beep_rem_d = BW'(BEEP_TICKS);
    end else if (buzz_q) begin
      if (beep_cnt_q == TICK_MAX) begin
        beep_cnt_d = '0;
        if (beep_rem_q != '0) beep_rem_d = beep_rem_q - 1'b1;
        if (beep_rem_q <= BW'(1)) buzz_d = 1'b0;
      end else begin
        beep_cnt_d = beep_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= S_IDLE;
      key_prev_q <= '1;
      foul_q     <= '0;
      pn_q       <= '0;
      timer_q    <= 1'b0;
      remain_q   <= '0;
      tick_cnt_q <= '0;
      score_q    <= '0;
      buzz_q     <= 1'b0;
      beep_cnt_q <= '0;
      beep_rem_q <= '0;
    end else begin
      state_q    <= state_d;
      key_prev_q <= Player_Key;
      foul_q     <= foul_d;
      pn_q       <= pn_d;
      timer_q    <= timer_d;
      remain_q   <= remain_d;
      tick_cnt_q <= tick_cnt_d;
      score_q    <= score_d;
      buzz_q     <= buzz_d;
      beep_cnt_q <= beep_cnt_d;
      beep_rem_q <= beep_rem_d;
    end
  end

  assign State         = state_q;
  assign Player_Number = pn_q;
  assign Foul          = foul_q;
  assign Timer_Start   = timer_q;
  assign Remain_Ticks  = remain_q;
  assign Score_Bus     = score_q;
  assign Buzzer_Answer = buzz_q;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Directed bench for quiz_round_ctrl: a per-cycle vector table plus hand-written
// sequences for countdown expiry, score saturation and mid-round reset.
module tb_quiz_round_ctrl;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        Host_Start = 1'b0, Judge_Right = 1'b0, Judge_Wrong = 1'b0, Score_Clr = 1'b0;
  logic [3:0]  Player_Key = 4'b0000;
  logic [3:0]  Player_Number, Foul;
  logic        Buzzer_Answer, Timer_Start;
  logic [7:0]  Remain_Ticks;
  logic [15:0] Score_Bus;
  logic [1:0]  State;

  quiz_round_ctrl #(
    .TICK_CYCLES(4), .GRAB_TICKS(9), .ANSWER_TICKS(5), .BEEP_TICKS(2), .SCORE_W(4)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .Host_Start(Host_Start), .Judge_Right(Judge_Right),
    .Judge_Wrong(Judge_Wrong), .Score_Clr(Score_Clr), .Player_Key(Player_Key),
    .Player_Number(Player_Number), .Buzzer_Answer(Buzzer_Answer), .Timer_Start(Timer_Start),
    .Remain_Ticks(Remain_Ticks), .Foul(Foul), .Score_Bus(Score_Bus), .State(State)
  );

  always #5 CLK = ~CLK;

  int unsigned total = 0, passed = 0;

  // {State, Player_Number, Foul, Timer_Start, Remain_Ticks, Buzzer_Answer, Score_Bus}
  logic [35:0] obs;
  assign obs = {State, Player_Number, Foul, Timer_Start, Remain_Ticks, Buzzer_Answer, Score_Bus};

  typedef struct {
    logic       host, right, wrong, clr;
    logic [3:0] keys;
    logic [1:0] st;
    logic [3:0] pn, foul;
    logic       tmr;
    logic [7:0] rem;
    logic       buz;
    logic [15:0] score;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input logic h, input logic r, input logic w, input logic c,
                      input logic [3:0] k);
    Host_Start = h; Judge_Right = r; Judge_Wrong = w; Score_Clr = c; Player_Key = k;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic do_reset();
    Host_Start = 1'b0; Judge_Right = 1'b0; Judge_Wrong = 1'b0; Score_Clr = 1'b0;
    Player_Key = 4'b0000;
    #2 RSTn = 1'b0;
    @(posedge CLK);
    #1 RSTn = 1'b1;
  endtask

  task automatic play(input logic [3:0] k, input logic r, input logic w);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 1'b0, 1'b0, k);
    step(1'b0, r, w, 1'b0, 4'b0000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bcount, done_cyc, rem_err;

    vecs[0]  = '{0,0,0,0,4'b0000, 2'd0,4'd0,4'b0000,0,8'd0,0,16'h0000};
    vecs[1]  = '{0,0,0,0,4'b0001, 2'd0,4'd0,4'b0001,0,8'd0,1,16'h0000};
    vecs[2]  = '{1,0,0,0,4'b0001, 2'd1,4'd0,4'b0001,1,8'd9,1,16'h0000};
    vecs[3]  = '{1,1,0,0,4'b0000, 2'd1,4'd0,4'b0001,1,8'd9,1,16'h0000};
    vecs[4]  = '{0,0,0,0,4'b0001, 2'd1,4'd0,4'b0001,1,8'd9,1,16'h0000};
    vecs[5]  = '{0,0,0,0,4'b0000, 2'd1,4'd0,4'b0001,1,8'd9,1,16'h0000};
    vecs[6]  = '{0,0,0,0,4'b0011, 2'd2,4'd2,4'b0001,1,8'd5,1,16'h0000};
    vecs[7]  = '{0,1,0,0,4'b0011, 2'd3,4'd2,4'b0001,0,8'd5,1,16'h0010};
    vecs[8]  = '{1,0,0,0,4'b0000, 2'd0,4'd0,4'b0000,0,8'd0,1,16'h0010};
    for (int i = 9; i < 14; i++)
      vecs[i] = '{0,0,0,0,4'b0000, 2'd0,4'd0,4'b0000,0,8'd0,1,16'h0010};
    vecs[14] = '{0,0,0,0,4'b0000, 2'd0,4'd0,4'b0000,0,8'd0,0,16'h0010};
    vecs[15] = '{0,0,0,1,4'b0000, 2'd0,4'd0,4'b0000,0,8'd0,0,16'h0000};

    #3;
    check("reset_outputs", {28'd0, obs}, 64'd0);
    @(posedge CLK);
    #1 RSTn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].host, vecs[i].right, vecs[i].wrong, vecs[i].clr, vecs[i].keys);
      check($sformatf("vec%0d", i), {28'd0, obs},
            {28'd0, vecs[i].st, vecs[i].pn, vecs[i].foul, vecs[i].tmr,
             vecs[i].rem, vecs[i].buz, vecs[i].score});
    end

    // P3 grabs 10 cycles after Start; beep lasts 8 cycles.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    idle(9);
    check("armed_remain_at_9", {State, Remain_Ticks}, {2'd1, 8'd7});
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);
    check("grab_p3", {State, Player_Number, Remain_Ticks, Timer_Start},
          {2'd2, 4'd3, 8'd5, 1'b1});
    bcount = int'(Buzzer_Answer);
    for (int i = 0; i < 11; i++) begin
      idle(1);
      bcount += int'(Buzzer_Answer);
    end
    check("beep_len", bcount, 8);

    // Grab window expires with no key.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    check("armed_entry", {State, Remain_Ticks, Timer_Start}, {2'd1, 8'd9, 1'b1});
    done_cyc = 0;
    rem_err = 0;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      idle(1);
      if (cyc % 4 == 0 && cyc <= 36 && Remain_Ticks != 8'(9 - cyc / 4)) rem_err++;
      if (State == 2'd3) begin
        done_cyc = cyc;
        break;
      end
    end
    check("grab_remain_seq", rem_err, 0);
    check("grab_expiry_cycle", done_cyc, 36);
    check("grab_expiry_outs", {Remain_Ticks, Player_Number, Timer_Start, Buzzer_Answer},
          {8'd0, 4'd0, 1'b0, 1'b1});

    // Score saturation, floor, judge priorities and Score_Clr priority.
    do_reset();
    for (int i = 0; i < 15; i++) play(4'b0001, 1'b1, 1'b0);
    check("score1_15", Score_Bus[3:0], 4'd15);
    play(4'b0001, 1'b1, 1'b0);
    check("score1_sat", Score_Bus[3:0], 4'd15);
    play(4'b0001, 1'b0, 1'b1);
    check("score1_wrong", Score_Bus[3:0], 4'd14);

    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
    idle(20);
    check("answer_timeout_floor", {State, Score_Bus[7:4], Timer_Start}, {2'd3, 4'd0, 1'b0});
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);

    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
    idle(19);
    check("answer_last_tick", {State, Remain_Ticks}, {2'd2, 8'd1});
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    check("judge_beats_expiry", {State, Score_Bus[7:4]}, {2'd3, 4'd1});
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);

    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
    check("right_wrong_ignored", {State, Score_Bus[3:0]}, {2'd2, 4'd14});
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
    check("clr_priority", {State, Score_Bus}, {2'd3, 16'h0000});
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);

    // Async reset mid-answer with P1 held.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
    check("p1_grab", {State, Player_Number}, {2'd2, 4'd1});
    #2 RSTn = 1'b0;
    #1;
    check("async_reset_outs", {28'd0, obs}, 64'd0);
    @(posedge CLK);
    #1 RSTn = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
    check("held_key_no_foul", {State, Foul, Buzzer_Answer}, {2'd0, 4'd0, 1'b0});
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0001);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
    check("held_key_no_grab", {State, Player_Number}, {2'd1, 4'd0});
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0011);
    check("p2_grab_after_reset", {State, Player_Number}, {2'd2, 4'd2});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
